sar_adc: RTL

- Successive-approximation ADC model in SV-RNM: converts a real input voltage to an n-bit code.
- Receive-side counterpart of the team's R-string DAC, with the same transfer function: code k ↔ k*vref/2^n.
- Internal trial DAC plus real-valued comparator, one bit resolved per clock.
- Sits between the analog front end and the digital control, with a start/done handshake.

---
 rtl/sar_adc.sv | 100 ++++++++++
 1 files changed

// File: rtl/sar_adc.sv
// sar_adc: successive-approximation ADC with a real-valued input.
// One sample cycle, then one code bit resolved per clock, MSB first.
module sar_adc #(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  real          vin,
  input  real          vref,
  output logic [n-1:0] Q,
  output logic         busy,
  output logic         done,
  output logic         ovr
);

  localparam int  IW = (n > 1) ? $clog2(n) : 1;
  localparam real FS = real'(2 ** n);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONV,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [n-1:0]  trial_q, trial_d;
  logic [n-1:0]  q_q, q_d;
  logic [IW-1:0] i_q, i_d;
  logic          ovr_q, ovr_d;
  real           vs_q, vs_d;
  real           vr_q, vr_d;
  real           vt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      trial_q <= '0;
      i_q     <= '0;
      q_q     <= '0;
      ovr_q   <= 1'b0;
      vs_q    <= 0.0;
      vr_q    <= 0.0;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      i_q     <= i_d;
      q_q     <= q_d;
      ovr_q   <= ovr_d;
      vs_q    <= vs_d;
      vr_q    <= vr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    i_d     = i_q;
    q_d     = q_q;
    ovr_d   = ovr_q;
    vs_d    = vs_q;
    vr_d    = vr_q;
    vt      = vr_q * real'(trial_q) / FS;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SAMPLE;
      end
      SAMPLE: begin
        vs_d         = vin;
        vr_d         = vref;
        trial_d      = '0;
        trial_d[n-1] = 1'b1;
        i_d          = IW'(n - 1);
        state_d      = CONV;
      end
      CONV: begin
        if (!(vs_q >= vt)) trial_d[i_q] = 1'b0;
        if (i_q != '0) begin
          trial_d[i_q - IW'(1)] = 1'b1;
          i_d = i_q - IW'(1);
        end else begin
          state_d = DONE;
          // A non-positive reference has no meaningful levels: force zero.
          q_d   = (vr_q <= 0.0) ? '0 : trial_d;
          ovr_d = (vr_q <= 0.0) || (vs_q < 0.0) || (vs_q >= vr_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Q    = q_q;
  assign ovr  = ovr_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
